// File: rtl/fixed_matmul_pkg.sv
// Shared helpers for the fixed_matmul family: tile element indexing and counter sizing.
package fixed_matmul_pkg;

    // Flat index of element (row, col) inside a P1 x P2 tile.
    function automatic int tile_elem_idx(input int row, input int col, input int p2);
        return row * p2 + col;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fixed_matmul_band_bank.sv
// One band bank: N2 tile slots written a whole tile at a time, read back as one
// full result row (all N2 tiles side by side) selected by row index.
module fixed_matmul_band_bank
    import fixed_matmul_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int IN1_PARALLELISM     = 4,
    parameter int IN2_PARALLELISM     = 4,
    parameter int IN2_NUM_PARALLELISM = 2,
    localparam int TILE_CNT_W         = cnt_width(IN2_NUM_PARALLELISM),
    localparam int ROW_CNT_W          = cnt_width(IN1_PARALLELISM)
) (
    input  logic                                                       i_clk,
    input  logic                                                       i_rst_n,
    input  logic                                                       i_wr_en,
    input  logic [TILE_CNT_W-1:0]                                      i_wr_slot,
    input  logic [IN1_PARALLELISM*IN2_PARALLELISM-1:0][DATA_WIDTH-1:0] i_wr_tile,
    input  logic [ROW_CNT_W-1:0]                                       i_rd_row,
    output logic [IN2_PARALLELISM*IN2_NUM_PARALLELISM-1:0][DATA_WIDTH-1:0] o_rd_data
);

    logic [IN2_NUM_PARALLELISM-1:0][IN1_PARALLELISM-1:0][IN2_PARALLELISM-1:0][DATA_WIDTH-1:0] r_mem;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            for (int r = 0; r < IN1_PARALLELISM; r++) begin
                for (int c = 0; c < IN2_PARALLELISM; c++) begin
                    r_mem[i_wr_slot][r][c] <= i_wr_tile[tile_elem_idx(r, c, IN2_PARALLELISM)];
                end
            end
        end
    end

    // Row r of the band is row r of every tile, tile j occupying columns j*P2 .. j*P2+P2-1.
    for (genvar j = 0; j < IN2_NUM_PARALLELISM; j++) begin : g_tile
        for (genvar c = 0; c < IN2_PARALLELISM; c++) begin : g_col
            assign o_rd_data[j*IN2_PARALLELISM+c] = r_mem[j][i_rd_row][c];
        end
    end

endmodule

// File: rtl/fixed_matmul_tile_gather.sv
// Gathers N2 result tiles into a row band and re-emits it one full row per beat,
// using two ping-pong banks so one band fills while the other drains.
module fixed_matmul_tile_gather
    import fixed_matmul_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int IN1_PARALLELISM     = 4,
    parameter int IN2_PARALLELISM     = 4,
    parameter int IN2_NUM_PARALLELISM = 2
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic [IN1_PARALLELISM*IN2_PARALLELISM-1:0][DATA_WIDTH-1:0]     data_in,
    input  logic                                                           data_in_valid,
    output logic                                                           data_in_ready,
    output logic [IN2_PARALLELISM*IN2_NUM_PARALLELISM-1:0][DATA_WIDTH-1:0] data_out,
    output logic                                                           data_out_valid,
    input  logic                                                           data_out_ready
);

    localparam int BAND_COLS  = IN2_PARALLELISM * IN2_NUM_PARALLELISM;
    localparam int TILE_CNT_W = cnt_width(IN2_NUM_PARALLELISM);
    localparam int ROW_CNT_W  = cnt_width(IN1_PARALLELISM);
    localparam logic [TILE_CNT_W-1:0] LAST_TILE = TILE_CNT_W'(IN2_NUM_PARALLELISM - 1);
    localparam logic [ROW_CNT_W-1:0]  LAST_ROW  = ROW_CNT_W'(IN1_PARALLELISM - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready. Both
    // data_in_ready and data_out_valid/data_out come from registers only, so
    // neither side ever sees a combinational path from the other's inputs.
    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [TILE_CNT_W-1:0] r_tile_cnt;
    logic [ROW_CNT_W-1:0]  r_row_cnt;

    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_tile_last;
    logic                  w_row_last;
    logic [1:0]            w_full_next;
    logic [BAND_COLS-1:0][DATA_WIDTH-1:0] w_bank_rd [2];

    assign data_in_ready  = !r_full[r_wr_bank];
    assign data_out_valid = r_full[r_rd_bank];
    assign w_wr_fire      = data_in_valid && data_in_ready;
    assign w_rd_fire      = data_out_ready && data_out_valid;
    assign w_tile_last    = (r_tile_cnt == LAST_TILE);
    assign w_row_last     = (r_row_cnt == LAST_ROW);

    // The write and read pointers can never name the same bank in one cycle
    // while both complete, so set and clear never collide on one flag.
    always_comb begin
        w_full_next = r_full;
        if (w_rd_fire && w_row_last) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_wr_fire && w_tile_last) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_tile_cnt <= '0;
            r_row_cnt  <= '0;
        end else begin
            r_full <= w_full_next;
            if (w_wr_fire) begin
                if (w_tile_last) begin
                    r_tile_cnt <= '0;
                    r_wr_bank  <= ~r_wr_bank;
                end else begin
                    r_tile_cnt <= r_tile_cnt + TILE_CNT_W'(1);
                end
            end
            if (w_rd_fire) begin
                if (w_row_last) begin
                    r_row_cnt <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_row_cnt <= r_row_cnt + ROW_CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fixed_matmul_band_bank #(
            .DATA_WIDTH          (DATA_WIDTH),
            .IN1_PARALLELISM     (IN1_PARALLELISM),
            .IN2_PARALLELISM     (IN2_PARALLELISM),
            .IN2_NUM_PARALLELISM (IN2_NUM_PARALLELISM)
        ) u_bank (
            .i_clk     (clk),
            .i_rst_n   (rst),
            .i_wr_en   (w_wr_fire && (r_wr_bank == 1'(g))),
            .i_wr_slot (r_tile_cnt),
            .i_wr_tile (data_in),
            .i_rd_row  (r_row_cnt),
            .o_rd_data (w_bank_rd[g])
        );
    end

    assign data_out = r_rd_bank ? w_bank_rd[1] : w_bank_rd[0];

endmodule

// File: tb/tb_fixed_matmul_tile_gather.sv
// Bench for fixed_matmul_tile_gather: a band-level model turns accepted tiles into
// expected rows, and each scenario task compares the DUT's rows against it.
module tb_fixed_matmul_tile_gather;

    localparam int DW     = 32;
    localparam int P1     = 4;
    localparam int P2     = 4;
    localparam int N2     = 2;
    localparam int TILE_N = P1 * P2;
    localparam int ROW_N  = P2 * N2;
    localparam int ROW_W  = DW * ROW_N;

    typedef logic [TILE_N-1:0][DW-1:0] tile_t;
    typedef logic [ROW_N-1:0][DW-1:0]  row_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    tile_t data_in = '0;
    logic  data_in_valid = 1'b0;
    logic  data_in_ready;
    row_t  data_out;
    logic  data_out_valid;
    logic  data_out_ready = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    tile_t             send_q[$];
    tile_t             band_tiles[$];
    logic [ROW_W-1:0]  exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fixed_matmul_tile_gather #(
        .DATA_WIDTH          (DW),
        .IN1_PARALLELISM     (P1),
        .IN2_PARALLELISM     (P2),
        .IN2_NUM_PARALLELISM (N2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    // ---------------- reference model ----------------
    // A band is N2 tiles; output row r holds row r of tile j at columns j*P2+c.
    task automatic model_accept(input tile_t t);
        row_t row;
        band_tiles.push_back(t);
        if (band_tiles.size() == N2) begin
            for (int r = 0; r < P1; r++) begin
                for (int j = 0; j < N2; j++) begin
                    for (int c = 0; c < P2; c++) begin
                        row[j*P2+c] = band_tiles[j][r*P2+c];
                    end
                end
                exp_q.push_back(row);
            end
            band_tiles.delete();
        end
    endtask

    task automatic model_reset();
        band_tiles.delete();
        exp_q.delete();
        send_q.delete();
    endtask

    function automatic tile_t rand_tile();
        tile_t t;
        for (int k = 0; k < TILE_N; k++) t[k] = $urandom();
        return t;
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: drive at the falling edge, sample just after, record handshakes.
    task automatic do_cycle(input logic in_v, input logic out_r,
                            output logic in_fire, output logic out_fire,
                            output row_t out_row, output logic in_rdy, output logic out_vld);
        tile_t t;
        @(negedge clk);
        data_in_valid  = in_v && (send_q.size() > 0);
        data_in        = (send_q.size() > 0) ? send_q[0] : '0;
        data_out_ready = out_r;
        #1;
        in_rdy   = data_in_ready;
        out_vld  = data_out_valid;
        out_row  = data_out;
        in_fire  = data_in_valid && data_in_ready;
        out_fire = out_r && data_out_valid;
        if (in_fire) begin
            t = send_q.pop_front();
            model_accept(t);
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst            = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset(3);
        #1;
        tests_run++;
        if (data_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", data_in_ready);
        end
        tests_run++;
        if (data_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b want 0", data_out_valid);
        end
        tests_run++;
        if (data_out !== row_t'('0)) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h want 0", data_out);
        end
    endtask

    task automatic test_one_band();
        tile_t t0, t1;
        logic  in_f, out_f, in_rdy, out_vld;
        row_t  out_row, exp_row;
        int    sent = 0, rows = 0, tile1_cyc = -1, cyc = 0;
        for (int k = 0; k < TILE_N; k++) begin
            t0[k] = DW'(k);
            t1[k] = DW'(100 + k);
        end
        send_q.push_back(t0);
        send_q.push_back(t1);
        while (rows < P1 && cyc < 40) begin
            do_cycle(1'b1, 1'b1, in_f, out_f, out_row, in_rdy, out_vld);
            if (cyc == tile1_cyc + 1 && tile1_cyc >= 0) begin
                tests_run++;
                if (out_vld !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL one_band_latency: valid %b want 1 one cycle after last tile", out_vld);
                end
            end
            if (sent < N2) begin
                tests_run++;
                if (out_vld !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL one_band_early_valid: valid %b want 0 before band complete", out_vld);
                end
            end
            if (in_f) begin
                sent++;
                if (sent == N2) tile1_cyc = cyc;
            end
            if (out_f) begin
                exp_row = exp_q.pop_front();
                tests_run++;
                if (out_row !== exp_row) begin
                    tests_failed++;
                    $display("FAIL one_band_row%0d: got %h want %h", rows, out_row, exp_row);
                end
                tests_run++;
                if (out_row[0] !== DW'(rows*P2) || out_row[P2] !== DW'(100 + rows*P2)) begin
                    tests_failed++;
                    $display("FAIL one_band_const%0d: got [0]=%0d [%0d]=%0d want %0d,%0d",
                             rows, out_row[0], P2, out_row[P2], rows*P2, 100 + rows*P2);
                end
                rows++;
            end
            cyc++;
        end
        tests_run++;
        if (rows != P1) begin
            tests_failed++;
            $display("FAIL one_band_count: got %0d rows want %0d", rows, P1);
        end
    endtask

    task automatic test_back_to_back();
        logic in_f, out_f, in_rdy, out_vld;
        row_t out_row, exp_row;
        int   rows = 0, bubbles = 0, cyc = 0, bad = 0;
        logic started = 1'b0;
        for (int i = 0; i < 6 * N2; i++) send_q.push_back(rand_tile());
        while (rows < 6 * P1 && cyc < 300) begin
            do_cycle(1'b1, 1'b1, in_f, out_f, out_row, in_rdy, out_vld);
            if (started && !out_f) bubbles++;
            if (out_f) begin
                started = 1'b1;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_row: got %h want no row", out_row);
                end else begin
                    exp_row = exp_q.pop_front();
                    if (out_row !== exp_row) begin
                        bad++;
                        $display("FAIL b2b_row%0d: got %h want %h", rows, out_row, exp_row);
                    end
                end
                rows++;
            end
            cyc++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_data: %0d bad rows want 0", bad);
        end
        tests_run++;
        if (rows != 6 * P1) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d rows want %0d", rows, 6 * P1);
        end
        tests_run++;
        if (bubbles != 0) begin
            tests_failed++;
            $display("FAIL b2b_bubbles: got %0d output bubbles want 0", bubbles);
        end
    endtask

    task automatic test_backpressure();
        logic in_f, out_f, in_rdy, out_vld;
        row_t out_row, exp_row, frozen;
        int   accepted = 0, unstable = 0, rows = 0, cyc = 0, first_in_rows = -1;
        logic have_frozen = 1'b0;
        logic last_rdy = 1'b1;
        for (int i = 0; i < 3 * N2; i++) send_q.push_back(rand_tile());
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 1'b0, in_f, out_f, out_row, in_rdy, out_vld);
            if (in_f) accepted++;
            last_rdy = in_rdy;
            if (have_frozen) begin
                if (!out_vld || out_row !== frozen) unstable++;
            end else if (out_vld) begin
                frozen      = out_row;
                have_frozen = 1'b1;
            end
        end
        tests_run++;
        if (accepted != 2 * N2) begin
            tests_failed++;
            $display("FAIL bp_accepted: got %0d tiles want %0d", accepted, 2 * N2);
        end
        tests_run++;
        if (last_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ready_low: got %b want 0 with both banks full", last_rdy);
        end
        tests_run++;
        if (!have_frozen || unstable != 0) begin
            tests_failed++;
            $display("FAIL bp_frozen: valid_seen=%b unstable_cycles=%0d want 1,0", have_frozen, unstable);
        end
        tests_run++;
        if (have_frozen && exp_q.size() > 0 && frozen !== row_t'(exp_q[0])) begin
            tests_failed++;
            $display("FAIL bp_frozen_value: got %h want %h", frozen, exp_q[0]);
        end
        while (rows < 3 * P1 && cyc < 200) begin
            do_cycle(1'b1, 1'b1, in_f, out_f, out_row, in_rdy, out_vld);
            if (in_f && first_in_rows < 0) first_in_rows = rows;
            if (out_f) begin
                exp_row = exp_q.pop_front();
                tests_run++;
                if (out_row !== exp_row) begin
                    tests_failed++;
                    $display("FAIL bp_row%0d: got %h want %h", rows, out_row, exp_row);
                end
                rows++;
            end
            cyc++;
        end
        tests_run++;
        if (first_in_rows != P1) begin
            tests_failed++;
            $display("FAIL bp_resume: band 2 accepted after %0d rows want %0d", first_in_rows, P1);
        end
        tests_run++;
        if (rows != 3 * P1) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d rows want %0d", rows, 3 * P1);
        end
    endtask

    task automatic test_random();
        logic in_f, out_f, in_rdy, out_vld;
        row_t out_row, exp_row;
        int   rows = 0, cyc = 0;
        for (int i = 0; i < 1000 * N2; i++) send_q.push_back(rand_tile());
        while (rows < 1000 * P1 && cyc < 60000) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     in_f, out_f, out_row, in_rdy, out_vld);
            if (out_f) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_unexpected_row: got %h want no row", out_row);
                end else begin
                    exp_row = exp_q.pop_front();
                    if (out_row !== exp_row) begin
                        tests_failed++;
                        $display("FAIL rand_row%0d: got %h want %h", rows, out_row, exp_row);
                    end
                end
                rows++;
            end
            cyc++;
        end
        tests_run++;
        if (rows != 1000 * P1 || exp_q.size() != 0 || send_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_complete: rows=%0d pending_exp=%0d pending_in=%0d want %0d,0,0",
                     rows, exp_q.size(), send_q.size(), 1000 * P1);
        end
    endtask

    task automatic test_reset_mid_band();
        logic in_f, out_f, in_rdy, out_vld;
        row_t out_row, exp_row;
        int   accepted = 0, rows = 0, cyc = 0, stray = 0;
        for (int i = 0; i < N2 + 1; i++) send_q.push_back(rand_tile());
        while (accepted < N2 && cyc < 20) begin
            do_cycle(1'b1, 1'b0, in_f, out_f, out_row, in_rdy, out_vld);
            if (in_f) accepted++;
            cyc++;
        end
        cyc = 0;
        while (rows < 2 && cyc < 20) begin
            do_cycle(1'b0, 1'b1, in_f, out_f, out_row, in_rdy, out_vld);
            if (out_f) begin
                exp_row = exp_q.pop_front();
                tests_run++;
                if (out_row !== exp_row) begin
                    tests_failed++;
                    $display("FAIL midrst_pre_row%0d: got %h want %h", rows, out_row, exp_row);
                end
                rows++;
            end
            cyc++;
        end
        do_cycle(1'b1, 1'b0, in_f, out_f, out_row, in_rdy, out_vld);
        tests_run++;
        if (in_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_tile_accept: got %b want 1", in_f);
        end
        apply_reset(1);
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 1'b1, in_f, out_f, out_row, in_rdy, out_vld);
            if (out_vld) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL midrst_stray: got %0d valid cycles after reset want 0", stray);
        end
        for (int i = 0; i < N2; i++) send_q.push_back(rand_tile());
        rows = 0;
        cyc  = 0;
        while (rows < P1 && cyc < 40) begin
            do_cycle(1'b1, 1'b1, in_f, out_f, out_row, in_rdy, out_vld);
            if (out_f) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL midrst_unexpected_row: got %h want no row", out_row);
                end else begin
                    exp_row = exp_q.pop_front();
                    if (out_row !== exp_row) begin
                        tests_failed++;
                        $display("FAIL midrst_post_row%0d: got %h want %h", rows, out_row, exp_row);
                    end
                end
                rows++;
            end
            cyc++;
        end
        tests_run++;
        if (rows != P1) begin
            tests_failed++;
            $display("FAIL midrst_post_count: got %0d rows want %0d", rows, P1);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_one_band();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_band();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
